riscv_multicycle_control: RTL

RISCV_MULTICYCLE_CONTROL -- requirements
Module: riscv_multicycle_control

---
 rtl/riscv_multicycle_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_control.sv
// Multicycle RISC-V control FSM: ld / sd / R-type / beq sequencing with
// Moore control outputs, a stall input, a retired-instruction counter and a
// sticky illegal-opcode flag.
// Optional build macro ILLEGAL_OP_TRAP_EN: an illegal opcode parks the FSM in
// TRAP until reset. Without it the FSM returns to FETCH.
module riscv_multicycle_control #(
  parameter logic [6:0] LD    = 7'b000_0011,
  parameter logic [6:0] SD    = 7'b010_0011,
  parameter logic [6:0] RTYPE = 7'b011_0011,
  parameter logic [6:0] BEQ   = 7'b110_0011
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        stall,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ALUSrcB,
  output logic        ALUSrcA,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic [3:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t      state_q, state_d;
  logic [31:0] retired_q;
  logic        illegal_q;
  logic        bad_op;
  logic        retire;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state decode; a stall freezes the state and cancels retire/illegal events
  always_comb begin
    state_d = state_q;
    bad_op  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == LD || opcode == SD) state_d = S_MEMADR;
        else if (opcode == RTYPE)         state_d = S_EXEC;
        else if (opcode == BEQ)           state_d = S_BRANCH;
        else begin
          bad_op  = 1'b1;
          state_d = ILL_NEXT;
        end
      end
      S_MEMADR: begin
        if (opcode == LD)      state_d = S_MEMRD;
        else if (opcode == SD) state_d = S_MEMWR;
        else begin
          bad_op  = 1'b1;
          state_d = ILL_NEXT;
        end
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
      S_MEMWR:  begin state_d = S_FETCH; retire = 1'b1; end
      S_EXEC:   state_d = S_RCOMP;
      S_RCOMP:  begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
    if (stall) begin
      state_d = state_q;
      bad_op  = 1'b0;
      retire  = 1'b0;
    end
  end

  // Moore control outputs; strobes are masked during stall and while in reset
  always_comb begin
    ALUOp       = '0;
    ALUSrcB     = '0;
    ALUSrcA     = 1'b0;
    MemtoReg    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RCOMP: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
    if (stall || !reset_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
    end
  end

  // Retired-instruction counter and sticky illegal flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) retired_q <= retired_q + 32'd1;
      if (bad_op) illegal_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule
